// File: rtl/iq_burst_framer.sv
// iq_burst_framer: frames a 16-bit I/Q symbol stream into bursts of pilot symbols followed by data.
// Build option IQ_GUARD_EN: append GUARD_LEN zero symbols after each data block.
module iq_burst_framer #(
   parameter int unsigned PREAMBLE_LEN = 4,
   parameter int unsigned BLOCK_LEN    = 96,
   parameter int unsigned GUARD_LEN    = 8,
   parameter logic [15:0] PRE_AMP      = 16'h5A82
) (
   input  logic        clk_100,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [15:0] I_in,
   input  logic [15:0] Q_in,
   output logic        ready_out,
   input  logic        ready_in,
   output logic        valid_out,
   output logic [15:0] I_out,
   output logic [15:0] Q_out,
   output logic        sof,
   output logic        eof
);

   localparam int unsigned MaxPb  = (PREAMBLE_LEN > BLOCK_LEN) ? PREAMBLE_LEN : BLOCK_LEN;
   localparam int unsigned MaxLen = (MaxPb > GUARD_LEN) ? MaxPb : GUARD_LEN;
   localparam int unsigned CntW   = $clog2(MaxLen + 1);

   localparam logic [CntW-1:0] PreLast  = CntW'(PREAMBLE_LEN - 1);
   localparam logic [CntW-1:0] DataLast = CntW'(BLOCK_LEN - 1);
   localparam logic [15:0]     PreNeg   = ~PRE_AMP + 16'd1;

`ifdef IQ_GUARD_EN
   localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_LEN - 1);

   typedef enum logic [1:0] {StIdle, StPreamble, StData, StGuard} state_e;
`else
   typedef enum logic [1:0] {StIdle, StPreamble, StData} state_e;
`endif

   state_e          state_q;
   logic [CntW-1:0] sym_cnt_q;

   logic [31:0] buf_q [2];
   logic [31:0] buf_d [2];
   logic [1:0]  fill_q, fill_d;
   logic [31:0] head;
   logic        buf_nonempty, push, pop, bypass, load_ok, next_burst;

   // Skid buffer with a bypass path so an accepted symbol can reach the output on the next edge.
   always_comb begin
      buf_nonempty = (fill_q != 2'd0);
      push         = valid_in & ready_out;
      load_ok      = ~valid_out | ready_in;
      pop          = (state_q == StData) & load_ok & (buf_nonempty | push);
      bypass       = pop & ~buf_nonempty;
      head         = buf_nonempty ? buf_q[0] : {I_in, Q_in};
      buf_d[0]     = buf_q[0];
      buf_d[1]     = buf_q[1];
      fill_d       = fill_q;
      if (pop && buf_nonempty) begin
         buf_d[0] = buf_q[1];
         fill_d   = fill_q - 2'd1;
      end
      if (push && !bypass) begin
         if (fill_d == 2'd0) begin
            buf_d[0] = {I_in, Q_in};
         end else begin
            buf_d[1] = {I_in, Q_in};
         end
         fill_d = fill_d + 2'd1;
      end
      next_burst = (fill_d != 2'd0) | valid_in;
   end

   always_ff @(posedge clk_100) begin
      if (reset) begin
         fill_q    <= 2'd0;
         ready_out <= 1'b0;
      end else begin
         fill_q    <= fill_d;
         ready_out <= (fill_d != 2'd2);
      end
   end

   always_ff @(posedge clk_100) begin
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
   end

   // State and counter describe the next symbol to be loaded into the output register.
   always_ff @(posedge clk_100) begin
      if (reset) begin
         state_q   <= StIdle;
         sym_cnt_q <= '0;
         valid_out <= 1'b0;
         I_out     <= 16'd0;
         Q_out     <= 16'd0;
         sof       <= 1'b0;
         eof       <= 1'b0;
      end else begin
         if (valid_out && ready_in) begin
            valid_out <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (buf_nonempty || valid_in) begin
                  state_q   <= StPreamble;
                  sym_cnt_q <= '0;
               end
            end
            StPreamble: begin
               if (load_ok) begin
                  valid_out <= 1'b1;
                  I_out     <= PRE_AMP;
                  Q_out     <= sym_cnt_q[0] ? PreNeg : PRE_AMP;
                  sof       <= (sym_cnt_q == '0);
                  eof       <= 1'b0;
                  if (sym_cnt_q == PreLast) begin
                     state_q   <= StData;
                     sym_cnt_q <= '0;
                  end else begin
                     sym_cnt_q <= sym_cnt_q + CntW'(1);
                  end
               end
            end
            StData: begin
               if (pop) begin
                  valid_out      <= 1'b1;
                  {I_out, Q_out} <= head;
                  sof            <= 1'b0;
                  if (sym_cnt_q == DataLast) begin
                     sym_cnt_q <= '0;
`ifdef IQ_GUARD_EN
                     eof       <= 1'b0;
                     state_q   <= StGuard;
`else
                     eof       <= 1'b1;
                     state_q   <= next_burst ? StPreamble : StIdle;
`endif
                  end else begin
                     eof       <= 1'b0;
                     sym_cnt_q <= sym_cnt_q + CntW'(1);
                  end
               end
            end
`ifdef IQ_GUARD_EN
            StGuard: begin
               if (load_ok) begin
                  valid_out <= 1'b1;
                  I_out     <= 16'd0;
                  Q_out     <= 16'd0;
                  sof       <= 1'b0;
                  if (sym_cnt_q == GuardLast) begin
                     eof       <= 1'b1;
                     sym_cnt_q <= '0;
                     state_q   <= next_burst ? StPreamble : StIdle;
                  end else begin
                     eof       <= 1'b0;
                     sym_cnt_q <= sym_cnt_q + CntW'(1);
                  end
               end
            end
`endif
            default: begin
               state_q   <= StIdle;
               sym_cnt_q <= '0;
            end
         endcase
      end
   end

endmodule
